// File: rtl/de_port_arbiter_pkg.sv
// Shared types and constants for the two-engine frame-store port arbiter.
package de_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W    = 18;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BEATS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

  function automatic logic [1:0] grant_of(input state_e s);
    case (s)
      ST_OWN0: grant_of = GRANT_P0;
      ST_OWN1: grant_of = GRANT_P1;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/de_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not own the bus last.
module de_port_arbiter_rr_pick2
  import de_port_arbiter_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       last_owner_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = GRANT_NONE;
    if (req0_i && req1_i) begin
      winner_o = last_owner_i ? GRANT_P0 : GRANT_P1;
    end else if (req0_i) begin
      winner_o = GRANT_P0;
    end else if (req1_i) begin
      winner_o = GRANT_P1;
    end else begin
      winner_o = GRANT_NONE;
    end
  end

endmodule

// File: rtl/de_port_arbiter.sv
// Shares one frame-store port between two drawing engines with round-robin
// grant and a bounded burst; the data path is a pure mux driven by the grant.
module de_port_arbiter
  import de_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  output logic                ack0,
  output logic                ack1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W/8-1:0] nbyte0,
  input  logic [DATA_W/8-1:0] nbyte1,
  input  logic                rnw0,
  input  logic                rnw1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_nbyte,
  output logic                mem_rnw,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int unsigned NB = DATA_W / 8;
  localparam logic [8:0] MAX_BEATS_W = 9'(MAX_BEATS);

  state_e     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] pick_s;
  logic       pick_last_s;
  logic       beat_s;
  logic       cnt_hit_s;

  // While a port owns the bus it passes itself as last owner, so the picker
  // names the other port whenever that one is waiting.
  always_comb begin
    case (state_q)
      ST_OWN0: pick_last_s = 1'b0;
      ST_OWN1: pick_last_s = 1'b1;
      default: pick_last_s = last_owner_q;
    endcase
  end

  de_port_arbiter_rr_pick2 u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_owner_i (pick_last_s),
    .winner_o     (pick_s)
  );

  always_comb begin
    grant     = grant_of(state_q);
    busy      = (grant_of(state_q) != GRANT_NONE);
    rdata     = mem_rdata;
    mem_req   = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_nbyte = {NB{1'b1}};
    mem_rnw   = 1'b0;
    mem_wdata = {DATA_W{1'b0}};
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state_q)
      ST_OWN0: begin
        mem_req   = req0;
        mem_addr  = addr0;
        mem_nbyte = nbyte0;
        mem_rnw   = rnw0;
        mem_wdata = wdata0;
        ack0      = mem_ack & req0;
      end
      ST_OWN1: begin
        mem_req   = req1;
        mem_addr  = addr1;
        mem_nbyte = nbyte1;
        mem_rnw   = rnw1;
        mem_wdata = wdata1;
        ack1      = mem_ack & req1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // The >= also releases a counter that saturated before the other port asked.
  always_comb begin
    beat_s    = ((state_q == ST_OWN0) && req0 && mem_ack) ||
                ((state_q == ST_OWN1) && req1 && mem_ack);
    cnt_hit_s = beat_s && (({1'b0, beat_cnt_q} + 9'd1) >= MAX_BEATS_W);
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s == GRANT_P0) begin
          state_d = ST_OWN0;
        end else if (pick_s == GRANT_P1) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          state_d      = (pick_s == GRANT_P1) ? ST_OWN1 : ST_IDLE;
          last_owner_d = 1'b0;
        end else if (cnt_hit_s && (pick_s == GRANT_P1)) begin
          state_d      = ST_OWN1;
          last_owner_d = 1'b0;
        end else begin
          state_d = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_d      = (pick_s == GRANT_P0) ? ST_OWN0 : ST_IDLE;
          last_owner_d = 1'b1;
        end else if (cnt_hit_s && (pick_s == GRANT_P0)) begin
          state_d      = ST_OWN0;
          last_owner_d = 1'b1;
        end else begin
          state_d = ST_OWN1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      beat_cnt_d = 8'd0;
    end else if (beat_s && ({1'b0, beat_cnt_q} < MAX_BEATS_W)) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // last_owner resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: doc/de_port_arbiter.md
Name: de_port_arbiter

Overview:
- Shares the single frame-store port (de_req/de_ack handshake, 18-bit word address, byte-lane enables, 32-bit data) between two drawing engines, e.g. the dithering engine (port 0) and a fill/line engine (port 1).
- Round-robin grant with a bounded burst length, so neither engine can starve the other during long scan-line runs.
- Sits between the engines' de_* outputs and the frame-store controller. Pure multiplexing of the data path; all sequencing lives in a small grant FSM.

Parameters:
- MAX_BEATS, 16, acks granted to one requester before a forced handover when the other is waiting (1..255).
- ADDR_W, 18, word address width.
- DATA_W, 32, data width; nbyte width is DATA_W/8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  de_req from engine 0 / engine 1
- ack0 / ack1  out  1  de_ack returned to engine 0 / engine 1
- addr0 / addr1  in  ADDR_W  engine word address
- nbyte0 / nbyte1  in  DATA_W/8  active-low byte enables
- rnw0 / rnw1  in  1  read-not-write
- wdata0 / wdata1  in  DATA_W  write data
- rdata  out  DATA_W  read data, broadcast to both engines
- mem_req  out  1  request to frame store
- mem_ack  in  1  frame-store acknowledge (one beat completes per cycle with mem_req & mem_ack)
- mem_addr  out  ADDR_W  muxed address
- mem_nbyte  out  DATA_W/8  muxed byte enables
- mem_rnw  out  1  muxed read-not-write
- mem_wdata  out  DATA_W  muxed write data
- mem_rdata  in  DATA_W  frame-store read data
- grant  out  2  one-hot current owner (00 when idle)
- busy  out  1  grant != 00

Behaviour:
- Reset (rst=1 at a posedge): state IDLE, grant=00, last_owner=1 (so port 0 wins first), beat_cnt=0. While grant=00: mem_req=0, ack0=ack1=0, mem_addr/nbyte/rnw/wdata=0, mem_nbyte=all ones. Reset mid-burst drops mem_req in the following cycle; the beat in flight is abandoned.
- FSM states: IDLE, OWN0, OWN1. Grant is registered; all data muxing is combinational from the grant.
- IDLE: if exactly one of req0/req1 is high, go to that OWNx. If both are high, go to the port != last_owner. One-cycle grant latency; mem_req is never asserted in IDLE.
- OWNx:
  - mem_req = reqx; mem_* fields come from port x.
  - ackx = mem_ack & reqx; ack of the other port = 0.
  - rdata = mem_rdata at all times.
- Beat counting: beat_cnt increments on each mem_req & mem_ack, saturating at MAX_BEATS, and clears on every grant change.
- Release from OWNx (the first matching rule applies):
  - reqx=0 and other req=1: go to OWN(other), last_owner=x.
  - reqx=0 and other req=0: go to IDLE, last_owner=x.
  - Ack this cycle makes beat_cnt+1 == MAX_BEATS, and the other req=1: go to OWN(other), last_owner=x. reqx stays high; engine x simply waits without ack.
  - Otherwise stay.
- A handover never occurs on a cycle without an ack while reqx is high, so no beat is split.
- Simultaneous ack and reqx falling: an ack is only forwarded while reqx=1. The engine must hold req until it sees ack (existing engine convention).
- mem_ack arriving while mem_req=0 is ignored.

Decomposition:
- Shared package: state encoding (IDLE/OWN0/OWN1), ADDR_W/DATA_W defaults, grant one-hot constants.
- One sub-module, rr_pick2: two requests plus last_owner in, one-hot winner out (combinational). Used by both the IDLE and handover logic.

Test Plan:
- Reset, then req0 alone for 3 beats with mem_ack every cycle: grant=01 one cycle after req0; ack0 pulses 3 times; mem_addr follows addr0; ack1 stays 0.
- req0 and req1 rise in the same cycle after reset: port 0 is granted first. When req0 drops, grant=10 on the next edge with no IDLE cycle.
- MAX_BEATS=4, req0 and req1 both held, mem_ack constant 1: grant alternates 01 (4 acks), 10 (4 acks), 01, and so on. No cycle has both acks; no beat is lost.
- Only req0 held for 40 beats with MAX_BEATS=16: no forced handover, grant stays 01 throughout.
- Write then read: port 1 writes nbyte=4'b1110 at addr 0x00123; port 0 reads the same address. mem_rnw and mem_nbyte switch with the grant; rdata equals mem_rdata.
- Assert rst while in OWN1 mid-burst: the next cycle shows grant=00, mem_req=0, busy=0. After rst drops with both reqs high, port 0 is granted first.
